truth_table_sweeper: RTL and testbench

- Sequencer that exhaustively exercises a 4-input, 1-output combinational circuit.
- Drives inputs D,C,B,A through vectors 0..15, waits a settle interval, then samples Y.
- Builds a 16-bit captured truth table and compares it bit-by-bit against an expected table latched at start.
- Sits between the circuit under test and a host that issues start and reads pass/fail.

---
 rtl/truth_table_sweeper.sv | 148 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sequencer that sweeps a 4-input combinational circuit through all 16 vectors and checks Y against an expected table.
// Optional feature: define SWEEPER_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        Y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic        fail_valid,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] expected_q, expected_d;
    logic [15:0] truth_table_q, truth_table_d;
    logic [4:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic        fail_valid_q, fail_valid_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        pass_q, pass_d;
    logic        miss;

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        wait_cnt_d     = wait_cnt_q;
        expected_d     = expected_q;
        truth_table_d  = truth_table_q;
        mismatch_cnt_d = mismatch_cnt_q;
        fail_valid_d   = fail_valid_q;
        first_fail_d   = first_fail_q;
        pass_d         = pass_q;
        miss           = (Y != expected_q[index_q]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    expected_d     = expected;
                    truth_table_d  = '0;
                    mismatch_cnt_d = '0;
                    fail_valid_d   = 1'b0;
                    first_fail_d   = '0;
                    pass_d         = 1'b0;
                    index_d        = '0;
                    wait_cnt_d     = '0;
                    state_d        = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_cnt_q == SETTLE_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = ST_SAMPLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                truth_table_d[index_q] = Y;
                if (miss) begin
                    mismatch_cnt_d = mismatch_cnt_q + 5'd1;
                    if (!fail_valid_q) begin
                        first_fail_d = index_q;
                        fail_valid_d = 1'b1;
                    end
                end
`ifdef SWEEPER_STOP_ON_FAIL_EN
                if (miss || index_q == 4'd15) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ST_SETTLE;
                end
`else
                if (index_q == 4'd15) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = ST_SETTLE;
                end
`endif
            end
            ST_DONE: begin
                // mismatch_cnt_q already includes the final SAMPLE here
                pass_d  = (mismatch_cnt_q == 5'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            index_q        <= '0;
            wait_cnt_q     <= '0;
            expected_q     <= '0;
            truth_table_q  <= '0;
            mismatch_cnt_q <= '0;
            fail_valid_q   <= 1'b0;
            first_fail_q   <= '0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            wait_cnt_q     <= wait_cnt_d;
            expected_q     <= expected_d;
            truth_table_q  <= truth_table_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            fail_valid_q   <= fail_valid_d;
            first_fail_q   <= first_fail_d;
            pass_q         <= pass_d;
        end
    end

    assign A            = index_q[0];
    assign B            = index_q[1];
    assign C            = index_q[2];
    assign D            = index_q[3];
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign truth_table  = truth_table_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign fail_valid   = fail_valid_q;
    assign first_fail   = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 2 and 1) checked every cycle against an elapsed-time model.
module tb_truth_table_sweeper;

`ifdef SWEEPER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [15:0] expected;
    logic [15:0] cut;          // truth table of the circuit under test
    logic [1:0]  a_o, b_o, c_o, d_o, y_i, busy_o, done_o, pass_o, fv_o;
    logic [15:0] tt_o [2];
    logic [4:0]  mm_o [2];
    logic [3:0]  ff_o [2];
    logic [3:0]  vec_o [2];

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          check_en = 1'b0;

    // model state per instance
    int unsigned period_m [2];
    bit          run_m [2];
    int unsigned t_m [2];
    logic [15:0] exp_m [2];
    logic [15:0] cut_m [2];

    for (genvar g = 0; g < 2; g++) begin : g_vec
        assign vec_o[g] = {d_o[g], c_o[g], b_o[g], a_o[g]};
        assign y_i[g]   = cut[vec_o[g]];
    end

    truth_table_sweeper #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .Y(y_i[0]),
        .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .truth_table(tt_o[0]),
        .mismatch_cnt(mm_o[0]), .fail_valid(fv_o[0]), .first_fail(ff_o[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .Y(y_i[1]),
        .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .truth_table(tt_o[1]),
        .mismatch_cnt(mm_o[1]), .fail_valid(fv_o[1]), .first_fail(ff_o[1])
    );

    task automatic chk(input string nm, input int unsigned i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0h want %0h", nm, i, $time, act, exp);
        end
    endtask

    function automatic int unsigned lowest(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return 0;
    endfunction

    function automatic int unsigned last_vec(input logic [15:0] diff);
        if (STOP && diff != 16'h0) return lowest(diff);
        return 15;
    endfunction

    function automatic logic [15:0] mask_n(input int unsigned n);
        if (n >= 16) return 16'hFFFF;
        return 16'((32'd1 << n) - 32'd1);
    endfunction

    function automatic int unsigned t_done(input int unsigned i);
        return (last_vec(cut_m[i] ^ exp_m[i]) + 1) * period_m[i];
    endfunction

    // Advance the model across one rising edge using the inputs presented to it
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                run_m[i] = 1'b0;
            end else if (start && (!run_m[i] || t_m[i] > t_done(i))) begin
                run_m[i] = 1'b1;
                t_m[i]   = 0;
                exp_m[i] = expected;
                cut_m[i] = cut;
            end else if (run_m[i] && t_m[i] < 100000) begin
                t_m[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                int unsigned idx, n, lv, td, mm, ff;
                logic [15:0] tt, dm;
                logic        bsy, dn, ps;
                idx = 0; tt = '0; mm = 0; ff = 0; bsy = 0; dn = 0; ps = 0;
                if (run_m[i]) begin
                    lv  = last_vec(cut_m[i] ^ exp_m[i]);
                    td  = (lv + 1) * period_m[i];
                    idx = (t_m[i] < td) ? t_m[i] / period_m[i] : lv;
                    n   = t_m[i] / period_m[i];
                    if (n > lv + 1) n = lv + 1;
                    tt  = cut_m[i] & mask_n(n);
                    dm  = (cut_m[i] ^ exp_m[i]) & mask_n(n);
                    mm  = $countones(dm);
                    ff  = lowest(dm);
                    bsy = (t_m[i] <= td);
                    dn  = (t_m[i] == td);
                    ps  = (t_m[i] > td) && (mm == 0);
                end
                chk("index", i, 32'(vec_o[i]), 32'(idx));
                chk("busy", i, 32'(busy_o[i]), 32'(bsy));
                chk("done", i, 32'(done_o[i]), 32'(dn));
                chk("pass", i, 32'(pass_o[i]), 32'(ps));
                chk("truth_table", i, 32'(tt_o[i]), 32'(tt));
                chk("mismatch_cnt", i, 32'(mm_o[i]), mm);
                chk("fail_valid", i, 32'(fv_o[i]), 32'(mm != 0));
                if (mm != 0) chk("first_fail", i, 32'(ff_o[i]), ff);
                else         chk("first_fail_rst", i, 32'(ff_o[i]), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int unsigned i, output int unsigned n);
        n = 0;
        while (!done_o[i] && n < 300) begin
            tick();
            n++;
        end
        if (!done_o[i]) chk("done_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        start = 1'b0;
        while ((busy_o[0] || busy_o[1]) && n < 300) begin
            tick();
            n++;
        end
        if (busy_o[0] || busy_o[1]) chk("idle_timeout", 0, 32'(busy_o), 32'd0);
    endtask

    task automatic launch(input logic [15:0] e, input logic [15:0] c);
        expected = e;
        cut      = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned n, dones;
        logic [15:0] e, flips;
        period_m[0] = 3;
        period_m[1] = 2;
        run_m[0] = 1'b0; run_m[1] = 1'b0;
        t_m[0] = 0; t_m[1] = 0;
        rst = 1'b1; start = 1'b0; expected = '0; cut = '0;
        @(negedge clk); #1;
        tick();
        check_en = 1'b1;
        start = 1'b1;               // rst dominates start
        tick();
        rst = 1'b0; start = 1'b0;
        chk("lit_reset_busy", 0, 32'(busy_o[0]), 32'd0);

        // Clean sweep
        launch(16'hA5C3, 16'hA5C3);
        wait_done(0, n);
        chk("lit_latency", 0, n, 32'd48);
        tick();
        chk("lit_tt", 0, 32'(tt_o[0]), 32'hA5C3);
        chk("lit_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("lit_mm", 0, 32'(mm_o[0]), 32'd0);
        chk("lit_fv", 0, 32'(fv_o[0]), 32'd0);
        chk("lit_idx_hold", 0, 32'(vec_o[0]), 32'd15);

        // Vectors 5 and 11 inverted
        wait_idle();
        launch(16'hA5C3, 16'hA5C3 ^ 16'h0820);
        wait_done(0, n);
`ifdef SWEEPER_STOP_ON_FAIL_EN
        chk("lit_latency_f", 0, n, 32'd18);
        tick();
        chk("lit_tt_f", 0, 32'(tt_o[0]), 32'h0023);
        chk("lit_mm_f", 0, 32'(mm_o[0]), 32'd1);
        chk("lit_idx_f", 0, 32'(vec_o[0]), 32'd5);
`else
        chk("lit_latency_f", 0, n, 32'd48);
        tick();
        chk("lit_tt_f", 0, 32'(tt_o[0]), 32'hADE3);
        chk("lit_mm_f", 0, 32'(mm_o[0]), 32'd2);
        chk("lit_idx_f", 0, 32'(vec_o[0]), 32'd15);
`endif
        chk("lit_ff_f", 0, 32'(ff_o[0]), 32'd5);
        chk("lit_fv_f", 0, 32'(fv_o[0]), 32'd1);
        chk("lit_pass_f", 0, 32'(pass_o[0]), 32'd0);

        // Repeated start while busy
        wait_idle();
        launch(16'hA5C3, 16'hA5C3);
        n = 0; dones = 0;
        while (!done_o[0] && n < 300) begin
            start = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        start = 1'b0;
        chk("lit_latency_rep", 0, n, 32'd48);
        for (int k = 0; k < 8; k++) begin
            if (done_o[0]) dones++;
            tick();
        end
        chk("lit_one_done", 0, dones, 32'd1);
        chk("lit_tt_rep", 0, 32'(tt_o[0]), 32'hA5C3);

        // Reset mid-sweep at index 7
        wait_idle();
        e = 16'($urandom);
        launch(e, e ^ 16'h0101);
        n = 0;
        while (vec_o[0] != 4'd7 && n < 100) begin
            tick();
            n++;
        end
        chk("lit_reach7", 0, 32'(vec_o[0]), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_idx", 0, 32'(vec_o[0]), 32'd0);
        chk("lit_rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("lit_rst_mm", 0, 32'(mm_o[0]), 32'd0);
        chk("lit_rst_done", 0, 32'(done_o[0]), 32'd0);
        launch(e, e);
        wait_done(0, n);
        chk("lit_latency_post", 0, n, 32'd48);
        tick();
        chk("lit_pass_post", 0, 32'(pass_o[0]), 32'd1);

        // Settle of 1, back-to-back sweeps with Y tied high
        wait_idle();
        launch(16'hFFFF, 16'hFFFF);
        wait_done(1, n);
        chk("lit_latency_s1a", 1, n, 32'd32);
        tick();
        chk("lit_pass_s1a", 1, 32'(pass_o[1]), 32'd1);
        launch(16'h0000, 16'hFFFF);
        wait_done(1, n);
        chk("lit_latency_s1b", 1, n, STOP ? 32'd2 : 32'd32);
        tick();
        chk("lit_mm_s1b", 1, 32'(mm_o[1]), STOP ? 32'd1 : 32'd16);
        chk("lit_ff_s1b", 1, 32'(ff_o[1]), 32'd0);
        chk("lit_pass_s1b", 1, 32'(pass_o[1]), 32'd0);

        // Randomized sweeps with noisy start/expected and rare resets
        for (int it = 0; it < 25; it++) begin
            wait_idle();
            case ($urandom_range(0, 3))
                0:       flips = '0;
                1:       flips = 16'(32'd1 << $urandom_range(0, 15));
                default: flips = 16'($urandom & $urandom);
            endcase
            e = 16'($urandom);
            launch(e, e ^ flips);
            for (int k = 0; k < int'($urandom_range(20, 70)); k++) begin
                start    = ($urandom_range(0, 7) == 0);
                expected = 16'($urandom);
                rst      = ($urandom_range(0, 149) == 0);
                tick();
            end
            rst = 1'b0;
        end
        wait_idle();
        tick();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
